seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver for `NUM_DIGITS` BCD digits.
- Captures a packed BCD word and decodes each digit to segments.
- Scans the digits one at a time at a programmable refresh rate.
- Defers new data to frame boundaries so a display never shows a mix of old and new digits.
- Sits between register/counter logic producing BCD values and the board's shared segment bus and digit enables.

---
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus between BCD producer logic and the seven-segment scan driver.
// The master drives enable/load/data_in; the driver (slave) returns segment and digit enables.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output enable, load, data_in,
    input  seg, dig_sel, frame_done, pending
  );

  modport slave (
    input  enable, load, data_in,
    output seg, dig_sel, frame_done, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS BCD digits with frame-aligned data commit.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tick;
  logic                  boundary;

  logic [NUM_DIGITS-1:0][6:0] digit_seg;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
`ifdef SEG7_LZB_EN
      if (gi == 0) begin : g_d0
        assign digit_seg[gi] = bcd_to_seg(disp_q[3:0]);
      end else begin : g_dk
        // A digit is a leading zero when it and every digit above it are zero
        assign digit_seg[gi] = (disp_q[DW-1:4*gi] == '0) ? 7'b0000000
                                                         : bcd_to_seg(disp_q[4*gi +: 4]);
      end
`else
      assign digit_seg[gi] = bcd_to_seg(disp_q[4*gi +: 4]);
`endif
    end
  endgenerate

  always_comb begin
    tick         = bus.enable && (pcnt_q == PCNT_LAST);
    boundary     = tick && (idx_q == IDX_LAST);
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;

    if (tick) begin
      pcnt_d = '0;
      idx_d  = boundary ? '0 : idx_q + IW'(1);
    end else if (bus.enable) begin
      pcnt_d = pcnt_q + PW'(1);
    end

    // A load on the boundary itself supersedes whatever sits in the shadow
    if (!bus.enable) begin
      if (bus.load) begin
        disp_d    = bus.data_in;
        pending_d = 1'b0;
      end
    end else if (boundary) begin
      if (bus.load) begin
        disp_d    = bus.data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end

    seg_d        = bus.enable ? digit_seg[idx_q] : 7'b0000000;
    dig_sel_d    = bus.enable ? (NUM_DIGITS'(1) << idx_q) : '0;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= '0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4 cycles per digit slot).
// Expected frames are queued by the stimulus; a negedge monitor collects each frame and checks it on frame_done.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   frame_no = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(4)) bus_if ();

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][6:0] seg;
    logic [3:0][2:0] cnt;
  } frame_t;

  frame_t exp_q[$];

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                         S9 = 7'b1111011, SB = 7'b0000000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] mask,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [2:0] c3, input logic [2:0] c2,
                            input logic [2:0] c1, input logic [2:0] c0);
    frame_t f;
    f.mask = mask;
    f.seg  = {s3, s2, s1, s0};
    f.cnt  = {c3, c2, c1, c0};
    exp_q.push_back(f);
  endtask

  task automatic push_full(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
    push_frame(4'hF, s3, s2, s1, s0, 3'd4, 3'd4, 3'd4, 3'd4);
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic load_at(input int n, input logic [15:0] value);
    step_to(n - 1);
    bus_if.load    = 1'b1;
    bus_if.data_in = value;
    step_to(n);
    bus_if.load    = 1'b0;
  endtask

  // Monitor: gather one displayed frame, compare it against the queue head on frame_done
  logic [6:0] rec_seg [4];
  int         rec_cnt [4];
  bit         rec_seen[4];
  bit         rec_conf[4];
  frame_t     cur;

  task automatic rec_clear();
    for (int i = 0; i < 4; i++) begin
      rec_seg[i]  = '0;
      rec_cnt[i]  = 0;
      rec_seen[i] = 1'b0;
      rec_conf[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    int d;
    if (!rst_n) begin
      rec_clear();
    end else begin
      case (bus_if.dig_sel)
        4'b0001: d = 0;
        4'b0010: d = 1;
        4'b0100: d = 2;
        4'b1000: d = 3;
        default: d = -1;
      endcase
      if (bus_if.dig_sel == 4'b0000) begin
        rec_clear();
      end else if (d < 0) begin
        chk("dig_sel_onehot", {28'd0, bus_if.dig_sel}, 32'd1);
      end else begin
        rec_cnt[d]++;
        if (!rec_seen[d]) begin
          rec_seen[d] = 1'b1;
          rec_seg[d]  = bus_if.seg;
        end else if (rec_seg[d] !== bus_if.seg) begin
          rec_conf[d] = 1'b1;
        end
      end
      if (bus_if.frame_done) begin
        frame_no++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_queue unexpected frame_done, actual=1 required=0 (frame %0d)", frame_no);
        end else begin
          cur = exp_q.pop_front();
          $display("frame %0d: d3..d0 seg %b %b %b %b cnt %0d %0d %0d %0d pending %b",
                   frame_no, rec_seg[3], rec_seg[2], rec_seg[1], rec_seg[0],
                   rec_cnt[3], rec_cnt[2], rec_cnt[1], rec_cnt[0], bus_if.pending);
          for (int i = 0; i < 4; i++) begin
            if (cur.mask[i]) begin
              chk($sformatf("frame%0d_d%0d_seg", frame_no, i),
                  {23'd0, rec_conf[i], rec_seen[i], rec_seg[i]}, {23'd0, 1'b0, 1'b1, cur.seg[i]});
              chk($sformatf("frame%0d_d%0d_cnt", frame_no, i), rec_cnt[i], {29'd0, cur.cnt[i]});
            end else begin
              chk($sformatf("frame%0d_d%0d_absent", frame_no, i), {31'd0, rec_seen[i]}, 32'd0);
            end
          end
          chk($sformatf("frame%0d_pending", frame_no), {31'd0, bus_if.pending}, 32'd0);
        end
        rec_clear();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.enable  = 1'b1;
    bus_if.load    = 1'b0;
    bus_if.data_in = 16'h0000;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_seg", {25'd0, bus_if.seg}, 32'd0);
    chk("rst_dig_sel", {28'd0, bus_if.dig_sel}, 32'd0);
    chk("rst_frame_done", {31'd0, bus_if.frame_done}, 32'd0);
    chk("rst_pending", {31'd0, bus_if.pending}, 32'd0);

    // Reset/scan: disp=0 shows 0 on every digit
    push_full(S0, S0, S0, S0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
    step_to(1);
    chk("scan_e1_dig_sel", {28'd0, bus_if.dig_sel}, 32'h1);
    chk("scan_e1_seg", {25'd0, bus_if.seg}, {25'd0, S0});
    step_to(5);
    chk("scan_e5_dig_sel", {28'd0, bus_if.dig_sel}, 32'h2);

    // Deferred load while idx=1: current frame keeps zeros
    push_full(S0, S0, S0, S0);
    load_at(22, 16'h1234);
    chk("defer_pending", {31'd0, bus_if.pending}, 32'd1);
    push_full(S1, S2, S3, S4);
    step_to(31);
    chk("defer_pending_late", {31'd0, bus_if.pending}, 32'd1);
    step_to(32);
    chk("defer_commit_pending", {31'd0, bus_if.pending}, 32'd0);

    // Collision: mid-frame 1111 then 5678 exactly on the boundary
    load_at(40, 16'h1111);
    chk("coll_pending", {31'd0, bus_if.pending}, 32'd1);
    push_full(S5, S6, S7, S8);
    load_at(48, 16'h5678);
    chk("coll_boundary_pending", {31'd0, bus_if.pending}, 32'd0);

    // Enable low while idx=2, immediate load, resume with held pcnt/idx
    push_frame(4'b1100, S0, S0, SB, SB, 3'd4, 3'd3, 3'd0, 3'd0);
    step_to(73);
    bus_if.enable = 1'b0;
    step_to(74);
    chk("dis_dig_sel", {28'd0, bus_if.dig_sel}, 32'd0);
    chk("dis_seg", {25'd0, bus_if.seg}, 32'd0);
    load_at(76, 16'h0009);
    chk("dis_load_pending", {31'd0, bus_if.pending}, 32'd0);
    step_to(79);
    bus_if.enable = 1'b1;
    push_full(S0, S0, S0, S9);
    step_to(80);
    chk("resume_dig_sel", {28'd0, bus_if.dig_sel}, 32'h4);
    chk("resume_seg", {25'd0, bus_if.seg}, {25'd0, S0});
    step_to(82);
    chk("resume_e82_dig_sel", {28'd0, bus_if.dig_sel}, 32'h4);
    step_to(83);
    chk("resume_e83_dig_sel", {28'd0, bus_if.dig_sel}, 32'h8);

    // Invalid codes
    load_at(95, 16'hFA90);
    push_full(SB, SB, S9, S0);

    // Leading-zero cases
    load_at(110, 16'h0050);
`ifdef SEG7_LZB_EN
    push_full(SB, SB, S5, S0);
`else
    push_full(S0, S0, S5, S0);
`endif
    load_at(126, 16'h0000);
`ifdef SEG7_LZB_EN
    push_full(SB, SB, SB, S0);
`else
    push_full(S0, S0, S0, S0);
`endif

    // Reset mid-frame with data pending: shadow is lost
    load_at(156, 16'h4321);
    chk("prereset_pending", {31'd0, bus_if.pending}, 32'd1);
    step_to(158);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", {25'd0, bus_if.seg}, 32'd0);
    chk("midrst_dig_sel", {28'd0, bus_if.dig_sel}, 32'd0);
    chk("midrst_pending", {31'd0, bus_if.pending}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
    push_full(S0, S0, S0, S0);
    step_to(17);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
